// File: rtl/flatten_pkg.sv
// -----------------------------------------------------------------------------
// flatten_pkg
// Shared definitions for the flatten sequencer: FSM state encoding and the
// default image geometry / transpose timeout used by flatten_seq.
// -----------------------------------------------------------------------------
package flatten_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FILL   = 3'd2,
        XPOSE  = 3'd3,
        SERVE  = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam int POOL_WORDS    = 128;  // pool-output words written per image
    localparam int FC_WORDS      = 32;   // flattened words served to FC1 per image
    localparam int XPOSE_TIMEOUT = 2047; // transpose cycles allowed before error

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter with synchronous clear that stops at MAX instead of wrapping.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, forces count to zero
//   clr   - synchronous clear, forces count to zero
//   en    - increment request (ignored once count == MAX)
//   count - current count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/flatten_seq.sv
// -----------------------------------------------------------------------------
// flatten_seq
// Sequences one image through the flatten stage: clears the reorder engine,
// accepts POOL_WORDS pool writes, runs the transpose engine until it reports
// done (or times out), then serves FC_WORDS reads to FC1 on request.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - one-cycle pulse starting an image (ignored while busy)
//   pool_valid    - pool stage presents a word
//   pool_ready    - write accepted (high throughout FILL)
//   pool_addr     - pool-side buffer write address
//   pool_we       - pool-side buffer write enable
//   flat_en       - transpose/reorder engine enable
//   flat_clear    - returns engine counters to zero
//   flatten_done  - engine reports reorder complete
//   fc_req        - FC1 requests the next word
//   fc1_en        - FC-side buffer read enable
//   fcin_addr     - FC-side buffer read address
//   fc_valid      - read data valid (fc1_en delayed one cycle)
//   busy          - sequencer is not idle
//   done          - one-cycle pulse alongside the final fc_valid
//   error         - sticky transpose-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module flatten_seq #(
    parameter int DATA_WIDTH    = 16,
    parameter int POOL_WORDS    = flatten_pkg::POOL_WORDS,
    parameter int FC_WORDS      = flatten_pkg::FC_WORDS,
    parameter int XPOSE_TIMEOUT = flatten_pkg::XPOSE_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        pool_valid,
    output logic                        pool_ready,
    output logic [$clog2(POOL_WORDS)-1:0] pool_addr,
    output logic                        pool_we,
    output logic                        flat_en,
    output logic                        flat_clear,
    input  logic                        flatten_done,
    input  logic                        fc_req,
    output logic                        fc1_en,
    output logic [$clog2(FC_WORDS)-1:0] fcin_addr,
    output logic                        fc_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    import flatten_pkg::*;

    localparam int AW = $clog2(POOL_WORDS);
    localparam int RW = $clog2(FC_WORDS);
    localparam int XW = $clog2(XPOSE_TIMEOUT + 1);

    localparam logic [AW-1:0] WR_LAST   = AW'(POOL_WORDS - 1);
    localparam logic [RW-1:0] RD_LAST   = RW'(FC_WORDS - 1);
    localparam logic [XW-1:0] XP_LIMIT  = XW'(XPOSE_TIMEOUT);
    localparam logic [XW-1:0] XP_FINAL  = XW'(XPOSE_TIMEOUT - 1);

    // Element width does not affect sequencing; reject only nonsense values.
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("flatten_seq: DATA_WIDTH must be at least 1");
    end

    state_t        state_q, state_d;
    logic          fc_valid_q;
    logic          error_q;
    logic          cnt_clr, wr_inc, xp_inc, rd_inc, timeout;
    logic [AW-1:0] wr_cnt;
    logic [XW-1:0] xp_cnt;
    logic [RW-1:0] rd_cnt;

    sat_counter #(.WIDTH(AW), .MAX(WR_LAST)) u_wr_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(wr_inc), .count(wr_cnt)
    );

    sat_counter #(.WIDTH(XW), .MAX(XP_LIMIT)) u_xp_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(xp_inc), .count(xp_cnt)
    );

    sat_counter #(.WIDTH(RW), .MAX(RD_LAST)) u_rd_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(rd_inc), .count(rd_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fc_valid_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fc_valid_q <= fc1_en;
            if (timeout) begin
                error_q <= 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        wr_inc     = 1'b0;
        xp_inc     = 1'b0;
        rd_inc     = 1'b0;
        timeout    = 1'b0;
        pool_ready = 1'b0;
        pool_we    = 1'b0;
        pool_addr  = '0;
        flat_en    = 1'b0;
        flat_clear = 1'b0;
        fc1_en     = 1'b0;
        fcin_addr  = '0;
        fc_valid   = fc_valid_q;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        error      = error_q;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                flat_clear = 1'b1;
                cnt_clr    = 1'b1;
                state_d    = FILL;
            end
            FILL: begin
                pool_ready = 1'b1;
                pool_we    = pool_valid;
                pool_addr  = wr_cnt;
                wr_inc     = pool_valid;
                if (pool_valid && (wr_cnt == WR_LAST)) state_d = XPOSE;
            end
            XPOSE: begin
                flat_en = 1'b1;
                xp_inc  = 1'b1;
                // A done seen on the last allowed cycle still wins over timeout.
                if (flatten_done) begin
                    state_d = SERVE;
                end else if (xp_cnt == XP_FINAL) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            SERVE: begin
                fc1_en    = fc_req;
                fcin_addr = rd_cnt;
                rd_inc    = fc_req;
                if (fc_req && (rd_cnt == RD_LAST)) state_d = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so while rst is high the old state is still in
        // the register; force the reset-level outputs here so the engine and
        // downstream stages see them immediately.
        if (rst) begin
            pool_ready = 1'b0;
            pool_we    = 1'b0;
            pool_addr  = '0;
            flat_en    = 1'b0;
            flat_clear = 1'b1;
            fc1_en     = 1'b0;
            fcin_addr  = '0;
            fc_valid   = 1'b0;
            busy       = 1'b0;
            done       = 1'b0;
            error      = 1'b0;
        end
    end

endmodule

// File: tb/tb_flatten_seq.sv
// -----------------------------------------------------------------------------
// tb_flatten_seq
// Directed image sequences with randomized handshakes against flatten_seq.
// Expected values come from transfer/grant counts kept by the bench.
// -----------------------------------------------------------------------------
module tb_flatten_seq;

    localparam int P_WORDS = 128;
    localparam int F_WORDS = 32;
    localparam int T_LIMIT = 2047;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pool_valid = 1'b0;
    logic       flatten_done = 1'b0;
    logic       fc_req = 1'b0;
    logic       pool_ready, pool_we, flat_en, flat_clear;
    logic       fc1_en, fc_valid, busy, done, error;
    logic [6:0] pool_addr;
    logic [4:0] fcin_addr;

    int n_checks = 0;
    int n_errors = 0;

    flatten_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .pool_valid(pool_valid), .pool_ready(pool_ready),
        .pool_addr(pool_addr), .pool_we(pool_we),
        .flat_en(flat_en), .flat_clear(flat_clear),
        .flatten_done(flatten_done), .fc_req(fc_req),
        .fc1_en(fc1_en), .fcin_addr(fcin_addr), .fc_valid(fc_valid),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, pool_ready, 0);
        check({tag, "_we"}, pool_we, 0);
        check({tag, "_paddr"}, pool_addr, 0);
        check({tag, "_flat_en"}, flat_en, 0);
        check({tag, "_flat_clear"}, flat_clear, 1);
        check({tag, "_fc1_en"}, fc1_en, 0);
        check({tag, "_faddr"}, fcin_addr, 0);
        check({tag, "_fc_valid"}, fc_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_clear", flat_clear, 0);
        next();
        start = 1'b0;
        @(negedge clk);
        check("clear_pulse", flat_clear, 1);
        check("clear_busy", busy, 1);
        check("clear_ready", pool_ready, 0);
        next();
    endtask

    // mode 0: back-to-back, 1: alternate 1/0, 2: random
    task automatic do_fill(input int mode);
        int xfers = 0;
        int cyc = 0;
        logic v;
        while (xfers < P_WORDS && cyc < 2000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            pool_valid = v;
            fc_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("fill_ready", pool_ready, 1);
            check("fill_we", pool_we, v);
            check("fill_addr", pool_addr, xfers);
            check("fill_flat_en", flat_en, 0);
            check("fill_fc1_en", fc1_en, 0);
            check("fill_clear", flat_clear, 0);
            if (v) xfers++;
            next();
            cyc++;
        end
        pool_valid = 1'b0;
        fc_req = 1'b0;
        check("fill_xfers", xfers, P_WORDS);
    endtask

    // n_done = cycle index (1-based) on which flatten_done is raised; 0 = never
    task automatic do_xpose(input int n_done, output int en_cycles);
        en_cycles = 0;
        for (int k = 1; k <= T_LIMIT; k++) begin
            flatten_done = (k == n_done);
            pool_valid = 1'($urandom_range(0, 1));
            fc_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("xp_flat_en", flat_en, 1);
            check("xp_we", pool_we, 0);
            check("xp_fc1_en", fc1_en, 0);
            check("xp_done", done, 0);
            check("xp_busy", busy, 1);
            if (flat_en === 1'b1) en_cycles++;
            next();
            if (k == n_done) break;
        end
        flatten_done = 1'b0;
        pool_valid = 1'b0;
        fc_req = 1'b0;
    endtask

    // mode 0: held, 1: pattern 1,0,0, 2: random; start pulsed at cycle start_at (-1 = none)
    task automatic do_serve(input int mode, input int start_at);
        int grants = 0;
        int cyc = 0;
        logic r;
        logic prev_en = 1'b0;
        while (grants < F_WORDS && cyc < 1000) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
            fc_req = r;
            start = (cyc == start_at);
            pool_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("srv_fc1_en", fc1_en, r);
            check("srv_addr", fcin_addr, grants);
            check("srv_fc_valid", fc_valid, prev_en);
            check("srv_flat_en", flat_en, 0);
            check("srv_we", pool_we, 0);
            check("srv_clear", flat_clear, 0);
            check("srv_busy", busy, 1);
            check("srv_done", done, 0);
            prev_en = r;
            if (r) grants++;
            next();
            cyc++;
        end
        start = 1'b0;
        pool_valid = 1'b0;
        check("srv_grants", grants, F_WORDS);
        fc_req = 1'b1;  // requests in FINISH must not be granted
        @(negedge clk);
        check("fin_fc1_en", fc1_en, 0);
        check("fin_fc_valid", fc_valid, 1);
        check("fin_done", done, 1);
        next();
        fc_req = 1'b0;
        @(negedge clk);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_fc_valid", fc_valid, 0);
    endtask

    task automatic run_image(input int fill_mode, input int n_done, input int serve_mode,
                             input int start_at);
        int en_cycles;
        do_start();
        do_fill(fill_mode);
        do_xpose(n_done, en_cycles);
        check("xp_en_cycles", en_cycles, n_done);
        do_serve(serve_mode, start_at);
        next();
    endtask

    initial begin
        int en_cycles;

        // Reset
        next();
        next();
        @(negedge clk);
        check_reset_outputs("rst");
        next();
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy0", busy, 0);
        check("idle_flat_clear0", flat_clear, 0);
        check("idle_error0", error, 0);
        next();

        // Full image, back-to-back traffic
        run_image(0, 1030, 0, -1);

        // Pool backpressure
        run_image(1, 1030, 0, -1);

        // Gapped FC read with a start pulse while serving
        run_image(0, 40, 1, 4);

        // Reset in the middle of XPOSE, then a clean image
        do_start();
        do_fill(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_xp_en", flat_en, 1);
            next();
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        next();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_rst_busy", busy, 0);
            check("after_rst_flat_en", flat_en, 0);
            check("after_rst_done", done, 0);
            next();
        end
        run_image(0, 1030, 0, -1);

        // Randomized images
        for (int i = 0; i < 3; i++) begin
            run_image(2, $urandom_range(1, T_LIMIT - 1), 2, $urandom_range(0, 20));
        end

        // Done raised on the last allowed cycle must beat the timeout
        run_image(0, T_LIMIT, 0, -1);
        check("edge_done_no_error", error, 0);

        // Transpose timeout
        do_start();
        do_fill(0);
        do_xpose(0, en_cycles);
        check("to_en_cycles", en_cycles, T_LIMIT);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_error", error, 1);
            check("to_busy", busy, 0);
            check("to_flat_en", flat_en, 0);
            check("to_done", done, 0);
            next();
        end
        rst = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        check("to_error_cleared", error, 0);
        next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flatten_seq.md
FLATTEN_SEQ -- requirements
Module: flatten_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the bit width of one feature element (informational; no data passes through the block).
REQ-002 The block SHALL have parameter POOL_WORDS, default 128, meaning the number of pool-output words written per image.
REQ-003 The block SHALL have parameter FC_WORDS, default 32, meaning the number of flattened words served to FC1 per image.
REQ-004 The block SHALL have parameter XPOSE_TIMEOUT, default 2047, meaning the maximum number of transpose cycles allowed before an error is flagged.
REQ-005 The block SHALL have port clk, input, width 1, the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1, a synchronous active-high reset.
REQ-007 The block SHALL have port start, input, width 1, a one-cycle pulse that begins a new image.
REQ-008 The block SHALL have port pool_valid, input, width 1, indicating the pool stage is presenting a word this cycle.
REQ-009 The block SHALL have port pool_ready, output, width 1, indicating the write is accepted (transfer = pool_valid & pool_ready).
REQ-010 The block SHALL have port pool_addr, output, width 7, the write address into the pool-side buffer.
REQ-011 The block SHALL have port pool_we, output, width 1, the write enable of the pool-side buffer.
REQ-012 The block SHALL have port flat_en, output, width 1, which enables the transpose/reorder engine.
REQ-013 The block SHALL have port flat_clear, output, width 1, which returns the engine counters to zero (layer-0 equivalent).
REQ-014 The block SHALL have port flatten_done, input, width 1, asserted by the engine when its reorder is complete.
REQ-015 The block SHALL have port fc_req, input, width 1, asserted by FC1 to request the next word.
REQ-016 The block SHALL have port fc1_en, output, width 1, the read enable of the FC-side buffer.
REQ-017 The block SHALL have port fcin_addr, output, width 5, the read address of the FC-side buffer.
REQ-018 The block SHALL have port fc_valid, output, width 1, asserted one cycle after fc1_en, when the read data is valid.
REQ-019 The block SHALL have port busy, output, width 1, asserted whenever the state is not IDLE.
REQ-020 The block SHALL have port done, output, width 1, a one-cycle pulse when the last FC word has been served.
REQ-021 The block SHALL have port error, output, width 1, a sticky flag set on transpose timeout and cleared only by rst.

Function
REQ-022 The FSM SHALL have the states IDLE, CLEAR, FILL, XPOSE, SERVE and FINISH.
REQ-023 IDLE->CLEAR SHALL occur on start; flat_clear SHALL be high for exactly the single CLEAR cycle; CLEAR->FILL SHALL follow unconditionally.
REQ-024 In FILL, pool_ready SHALL equal 1, pool_we SHALL equal pool_valid, and pool_addr SHALL equal the write counter.
REQ-025 The write counter SHALL increment on each transfer; the transfer at address POOL_WORDS-1 SHALL move the FSM to XPOSE on the next cycle with no wrap-around write.
REQ-026 In XPOSE, flat_en SHALL be held high and a cycle counter SHALL increment every cycle.
REQ-027 A sampled flatten_done SHALL move the FSM to SERVE on the next cycle, with flat_en low from that cycle onward.
REQ-028 If the cycle counter reaches XPOSE_TIMEOUT without flatten_done, error SHALL be set and the FSM SHALL go to IDLE.
REQ-029 In SERVE, fc_req high SHALL assert fc1_en in the same cycle with fcin_addr equal to the read counter, and the counter SHALL increment.
REQ-030 fc_valid SHALL be fc1_en delayed by one cycle.
REQ-031 A grant at address FC_WORDS-1 SHALL move the FSM to FINISH, and fc1_en SHALL be suppressed in FINISH.
REQ-032 FINISH SHALL pulse done for one cycle, coincident with the final fc_valid, and SHALL then return to IDLE.
REQ-033 A start pulse while busy SHALL be ignored.
REQ-034 pool_valid outside FILL and fc_req outside SERVE SHALL be ignored (no counter changes).
REQ-035 Counter widths SHALL be $clog2 of their limits; the XPOSE counter SHALL be 11 bits and SHALL saturate.

Reset
REQ-036 Under rst the state SHALL be IDLE and all counters zero.
REQ-037 Under rst the outputs pool_ready, pool_we, flat_en, fc1_en, fc_valid, busy, done and error SHALL all be 0.
REQ-038 Under rst pool_addr and fcin_addr SHALL be 0, and flat_clear SHALL be 1 so that the engine is reset as well.
REQ-039 rst asserted mid-operation SHALL abort on the next edge, with no done pulse.

Structure
REQ-040 The state encoding and the constants POOL_WORDS, FC_WORDS and XPOSE_TIMEOUT SHALL reside in a shared package, flatten_pkg.
REQ-041 The block SHALL instantiate one sub-module, sat_counter, a parameterised enable/clear/saturating counter used for the write, transpose and read counters.

Verification
REQ-042 The bench SHALL cover a full image: start, 128 back-to-back pool_valid, flatten_done after 1030 cycles, fc_req held 32 cycles -> 128 writes to addresses 0..127, flat_en high for exactly 1030 cycles, fcin_addr 0..31, and done one cycle after the last grant.
REQ-043 The bench SHALL cover pool backpressure: pool_valid toggling 1/0 in FILL -> pool_addr advances only on transfers and XPOSE is entered after the 128th transfer.
REQ-044 The bench SHALL cover timeout: flatten_done held low -> error=1 after 2047 XPOSE cycles, state IDLE, done never asserted.
REQ-045 The bench SHALL cover a gapped FC read: fc_req pattern 1,0,0,1... -> fc_valid follows fc1_en by one cycle and the read counter never skips.
REQ-046 The bench SHALL cover reset mid-XPOSE: rst for 1 cycle -> flat_en=0, flat_clear=1, busy=0, and a subsequent start runs a clean image.
REQ-047 The bench SHALL cover start while busy: a start pulse in SERVE -> no state change and counters unaffected.
